apb_slave_regbank: RTL and testbench

Parametrised APB slave for the AHB-to-APB bridge's peripheral side: NUM_SEL independent register banks, one per select line. Each bank holds REG_DEPTH words of DATA_WIDTH bits. It adds the following to the bridge's APB path:
- real storage, so reads return previously written data;
- programmable wait states via Pready;
- error signalling via Pslverr.

---
 rtl/apb_slave_regbank_if.sv | 26 ++
 rtl/apb_slave_regbank.sv | 132 +++++++++++++
 tb/tb_apb_slave_regbank.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/apb_slave_regbank_if.sv
// APB bus bundle between the bridge (master) and the register-bank slave.
// Clock and reset are carried as plain ports on the slave, not in here.
interface apb_slave_regbank_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_SEL    = 3
) ();
    logic [NUM_SEL-1:0]    Pselx;
    logic                  Penable;
    logic                  Pwrite;
    logic [ADDR_WIDTH-1:0] Paddr;
    logic [DATA_WIDTH-1:0] Pwdata;
    logic [DATA_WIDTH-1:0] Prdata;
    logic                  Pready;
    logic                  Pslverr;

    modport master (
        output Pselx, Penable, Pwrite, Paddr, Pwdata,
        input  Prdata, Pready, Pslverr
    );

    modport slave (
        input  Pselx, Penable, Pwrite, Paddr, Pwdata,
        output Prdata, Pready, Pslverr
    );
endinterface

// File: rtl/apb_slave_regbank.sv
// APB slave with NUM_SEL independent word-addressed register banks,
// programmable wait states and error response on bad select/address.
//
// state  | meaning
// IDLE   | waiting for a setup phase (Pselx != 0, Penable = 0)
// ACCESS | transfer latched; counting wait states, completes when counter = 0
module apb_slave_regbank #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int NUM_SEL     = 3,
    parameter int REG_DEPTH   = 8,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                  Pclk,
    input  logic                  Preset,
    apb_slave_regbank_if.slave    bus
);

    localparam int IDX_W  = $clog2(REG_DEPTH);
    localparam int BANK_W = (NUM_SEL > 1) ? $clog2(NUM_SEL) : 1;
    localparam logic [NUM_SEL-1:0] SEL_ONE = NUM_SEL'(1);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [BANK_W-1:0]     bank_q, bank_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  write_q, write_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] mem_q [NUM_SEL][REG_DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [NUM_SEL][REG_DEPTH];

    logic                  sel_onehot;
    logic                  addr_misaligned;
    logic                  addr_out_of_range;
    logic [BANK_W-1:0]     sel_enc;
    logic                  complete;

    // Request decode; only sampled into the latches during the setup phase.
    always_comb begin
        sel_onehot        = (bus.Pselx != '0) &&
                            ((bus.Pselx & (bus.Pselx - SEL_ONE)) == '0);
        addr_misaligned   = (bus.Paddr[1:0] != 2'b00);
        addr_out_of_range = ((bus.Paddr >> (IDX_W + 2)) != '0);
        sel_enc           = '0;
        for (int i = 0; i < NUM_SEL; i++) begin
            if (bus.Pselx[i]) begin
                sel_enc = BANK_W'(i);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bank_d   = bank_q;
        idx_d    = idx_q;
        write_d  = write_q;
        wdata_d  = wdata_q;
        err_d    = err_q;
        mem_d    = mem_q;
        complete = 1'b0;

        case (state_q)
            IDLE: begin
                if ((bus.Pselx != '0) && !bus.Penable) begin
                    err_d   = !sel_onehot || addr_misaligned || addr_out_of_range;
                    // Errored requests park on bank 0 so the read mux stays in range.
                    bank_d  = sel_onehot ? sel_enc : '0;
                    idx_d   = bus.Paddr[IDX_W+1:2];
                    write_d = bus.Pwrite;
                    wdata_d = bus.Pwdata;
                    cnt_d   = 4'(WAIT_CYCLES);
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (bus.Pselx == '0) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (bus.Penable) begin
                    if (cnt_q != 4'd0) begin
                        cnt_d = cnt_q - 4'd1;
                    end else begin
                        complete = 1'b1;
                        state_d  = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (complete && write_q && !err_q) begin
            mem_d[bank_q][idx_q] = wdata_q;
        end
    end

    always_ff @(posedge Pclk or posedge Preset) begin
        if (Preset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bank_q  <= '0;
            idx_q   <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            mem_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bank_q  <= bank_d;
            idx_q   <= idx_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            mem_q   <= mem_d;
        end
    end

    // Responses come only from latched request state, never from Paddr/Pwdata.
    assign bus.Pready  = complete;
    assign bus.Pslverr = complete && err_q;
    assign bus.Prdata  = (complete && !write_q && !err_q) ? mem_q[bank_q][idx_q] : '0;

endmodule

// File: tb/tb_apb_slave_regbank.sv
// Directed + random bench for apb_slave_regbank: one instance with no wait
// states, one with three, both checked against a plain array model.
module tb_apb_slave_regbank;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int NS = 3;
    localparam int RD = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst   [2];
    logic [NS-1:0] sel   [2];
    logic          en    [2];
    logic          wr    [2];
    logic [AW-1:0] addr  [2];
    logic [DW-1:0] wdata [2];

    apb_slave_regbank_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_SEL(NS)) bus0 ();
    apb_slave_regbank_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_SEL(NS)) bus1 ();

    assign bus0.Pselx   = sel[0];
    assign bus0.Penable = en[0];
    assign bus0.Pwrite  = wr[0];
    assign bus0.Paddr   = addr[0];
    assign bus0.Pwdata  = wdata[0];
    assign bus1.Pselx   = sel[1];
    assign bus1.Penable = en[1];
    assign bus1.Pwrite  = wr[1];
    assign bus1.Paddr   = addr[1];
    assign bus1.Pwdata  = wdata[1];

    apb_slave_regbank #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_SEL(NS),
                        .REG_DEPTH(RD), .WAIT_CYCLES(0)) u_dut0 (
        .Pclk   (clk),
        .Preset (rst[0]),
        .bus    (bus0)
    );

    apb_slave_regbank #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_SEL(NS),
                        .REG_DEPTH(RD), .WAIT_CYCLES(3)) u_dut1 (
        .Pclk   (clk),
        .Preset (rst[1]),
        .bus    (bus1)
    );

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] mem_m [2][NS][RD];
    int waits_of [2] = '{0, 3};

    task automatic chk(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rdy_of(int u);
        return (u == 0) ? DW'(bus0.Pready) : DW'(bus1.Pready);
    endfunction

    function automatic logic [DW-1:0] err_of(int u);
        return (u == 0) ? DW'(bus0.Pslverr) : DW'(bus1.Pslverr);
    endfunction

    function automatic logic [DW-1:0] rdata_of(int u);
        return (u == 0) ? bus0.Prdata : bus1.Prdata;
    endfunction

    task automatic quiet_chk(int u, string tag);
        chk({tag, "_pready"},  rdy_of(u),   '0);
        chk({tag, "_pslverr"}, err_of(u),   '0);
        chk({tag, "_prdata"},  rdata_of(u), '0);
    endtask

    function automatic void clear_model(int u);
        for (int b = 0; b < NS; b++)
            for (int i = 0; i < RD; i++)
                mem_m[u][b][i] = '0;
    endfunction

    // Full transfer from setup to completion; entered and left at posedge+1.
    task automatic xfer(int u, logic [NS-1:0] s, logic [AW-1:0] a, logic w,
                        logic [DW-1:0] d, string tag);
        bit err;
        int bank;
        int idx;
        logic [DW-1:0] exp;
        err  = ($countones(s) != 1) || (a % 4 != 0) || (a >= AW'(RD * 4));
        bank = 0;
        for (int i = 0; i < NS; i++) if (s[i]) bank = i;
        idx  = int'((a / 4) % RD);
        exp  = (!w && !err) ? mem_m[u][bank][idx] : '0;

        sel[u] = s; addr[u] = a; wr[u] = w; wdata[u] = d; en[u] = 1'b0;
        @(negedge clk); quiet_chk(u, {tag, "_setup"});
        @(posedge clk); #1 en[u] = 1'b1;
        repeat (waits_of[u]) begin
            @(negedge clk); quiet_chk(u, {tag, "_wait"});
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk({tag, "_done_pready"},  rdy_of(u),   DW'(1));
        chk({tag, "_done_pslverr"}, err_of(u),   DW'(err));
        chk({tag, "_done_prdata"},  rdata_of(u), exp);
        @(posedge clk); #1;
        if (w && !err) mem_m[u][bank][idx] = d;
        sel[u] = '0; en[u] = 1'b0;
    endtask

    // Write that loses Pselx after one wait state; must leave storage alone.
    task automatic abort_wr(int u, logic [NS-1:0] s, logic [AW-1:0] a, logic [DW-1:0] d);
        sel[u] = s; addr[u] = a; wr[u] = 1'b1; wdata[u] = d; en[u] = 1'b0;
        @(posedge clk); #1 en[u] = 1'b1;
        @(negedge clk); quiet_chk(u, "abort_wait");
        @(posedge clk); #1 sel[u] = '0; en[u] = 1'b0;
        @(negedge clk); quiet_chk(u, "abort_dropped");
        @(posedge clk); #1;
    endtask

    task automatic enable_no_setup(int u);
        sel[u] = 3'b001; addr[u] = 32'h4; wr[u] = 1'b1; wdata[u] = 32'hA5A5A5A5; en[u] = 1'b1;
        repeat (3) begin
            @(negedge clk); quiet_chk(u, "penable_no_setup");
            @(posedge clk); #1;
        end
        sel[u] = '0; en[u] = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic random_run(int u, int n);
        logic [NS-1:0] bad_sel [3] = '{3'b011, 3'b110, 3'b111};
        logic [NS-1:0] s;
        logic [AW-1:0] a;
        int r;
        for (int k = 0; k < n; k++) begin
            r = $urandom_range(0, 9);
            s = (r < 8) ? NS'(1 << $urandom_range(0, 2)) : bad_sel[$urandom_range(0, 2)];
            a = AW'($urandom_range(0, RD - 1) * 4);
            r = $urandom_range(0, 9);
            if (r == 8) a = a + AW'($urandom_range(1, 3));
            if (r == 9) a = a | (AW'(1) << $urandom_range(5, 31));
            xfer(u, s, a, 1'($urandom_range(0, 1)), $urandom, "rand");
        end
    endtask

    initial begin
        for (int u = 0; u < 2; u++) begin
            rst[u] = 1'b1; sel[u] = '0; en[u] = 1'b0; wr[u] = 1'b0;
            addr[u] = '0; wdata[u] = '0;
            clear_model(u);
        end
        @(negedge clk);
        quiet_chk(0, "reset0");
        quiet_chk(1, "reset1");
        @(posedge clk); #1 rst[0] = 1'b0; rst[1] = 1'b0;

        // Zero-wait instance: write/read, bank isolation, error cases.
        xfer(0, 3'b010, 32'h0C, 1'b1, 32'hDEADBEEF, "wr_deadbeef");
        xfer(0, 3'b010, 32'h0C, 1'b0, '0,           "rd_deadbeef");
        xfer(0, 3'b001, 32'h0C, 1'b0, '0,           "rd_other_bank");
        xfer(0, 3'b010, 32'h0D, 1'b1, 32'h11111111, "err_misaligned_wr");
        xfer(0, 3'b010, 32'h0D, 1'b0, '0,           "err_misaligned_rd");
        xfer(0, 3'b010, 32'h20, 1'b1, 32'h22222222, "err_range_wr");
        xfer(0, 3'b011, 32'h0C, 1'b1, 32'h33333333, "err_sel_wr");
        xfer(0, 3'b010, 32'h0C, 1'b0, '0,           "rd_after_errs");
        xfer(0, 3'b001, 32'h0C, 1'b0, '0,           "rd_bank0_after_errs");
        xfer(0, 3'b100, 32'h1C, 1'b1, 32'hCAFEF00D, "b2b_wr");
        xfer(0, 3'b100, 32'h1C, 1'b0, '0,           "b2b_rd");
        enable_no_setup(0);
        xfer(0, 3'b001, 32'h04, 1'b0, '0,           "rd_after_penable_only");

        // Three-wait instance: timing, abort, protocol corners.
        xfer(1, 3'b100, 32'h1C, 1'b1, 32'h0BADF00D, "w3_wr");
        xfer(1, 3'b100, 32'h1C, 1'b0, '0,           "w3_rd");
        abort_wr(1, 3'b100, 32'h1C, 32'hFFFFFFFF);
        xfer(1, 3'b100, 32'h1C, 1'b0, '0,           "w3_rd_after_abort");
        enable_no_setup(1);
        xfer(1, 3'b010, 32'h00, 1'b0, '0,           "w3_rd_zero");

        random_run(0, 60);
        random_run(1, 40);

        // Asynchronous reset in the middle of a completing read.
        xfer(0, 3'b001, 32'h0C, 1'b1, 32'h12345678, "pre_rst_wr");
        sel[0] = 3'b001; addr[0] = 32'h0C; wr[0] = 1'b0; en[0] = 1'b0;
        @(posedge clk); #1 en[0] = 1'b1;
        @(negedge clk);
        chk("pre_rst_pready", rdy_of(0),   DW'(1));
        chk("pre_rst_prdata", rdata_of(0), 32'h12345678);
        #2 rst[0] = 1'b1;
        #1 quiet_chk(0, "rst_async");
        sel[0] = '0; en[0] = 1'b0;
        clear_model(0);
        @(posedge clk); #1 rst[0] = 1'b0;
        xfer(0, 3'b001, 32'h0C, 1'b0, '0, "post_rst_rd");
        xfer(0, 3'b010, 32'h0C, 1'b0, '0, "post_rst_rd_bank1");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
